// File: rtl/rr_mux_4to1.sv
// Four-channel round-robin collector with a registered output stage.
// Each beat carries its source index, and packets may lock the grant until in_last.
module rr_mux_4to1 #(
    parameter int DATA_W  = 8,
    parameter bit LOCK_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DATA_W-1:0]   in_data,
    input  logic [3:0]            in_valid,
    input  logic [3:0]            in_last,
    output logic [3:0]            in_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [1:0]            out_sel,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef enum logic {ARB, HOLD} state_t;

    state_t             state_reg, state_next;
    logic [1:0]         owner_reg, owner_next;
    logic [1:0]         last_grant_reg, last_grant_next;
    logic [3:0]         grant;
    logic [1:0]         grant_idx;
    logic [1:0]         scan_idx;
    logic               found;
    logic               load_en;
    logic               xfer;
    logic [DATA_W-1:0]  chan_data [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chan
            assign chan_data[gi] = in_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Scan starts one past the last served channel so every requester gets a turn.
    always_comb begin
        grant     = 4'b0000;
        grant_idx = 2'd0;
        scan_idx  = 2'd0;
        found     = 1'b0;
        if (state_reg == HOLD) begin
            if (in_valid[owner_reg]) begin
                grant[owner_reg] = 1'b1;
                grant_idx        = owner_reg;
            end
        end else begin
            for (int k = 1; k <= 4; k++) begin
                scan_idx = last_grant_reg + 2'(k);
                if (!found && in_valid[scan_idx]) begin
                    found           = 1'b1;
                    grant[scan_idx] = 1'b1;
                    grant_idx       = scan_idx;
                end
            end
        end
    end

    assign load_en  = ~out_valid | out_ready;
    assign in_ready = (load_en && !rst) ? grant : 4'b0000;
    assign xfer     = |(in_valid & in_ready);

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_grant_next = last_grant_reg;
        if (xfer) begin
            case (state_reg)
                ARB: begin
                    if (in_last[grant_idx] || !LOCK_EN) begin
                        last_grant_next = grant_idx;
                    end else begin
                        state_next = HOLD;
                        owner_next = grant_idx;
                    end
                end
                HOLD: begin
                    if (in_last[owner_reg]) begin
                        state_next      = ARB;
                        last_grant_next = owner_reg;
                    end
                end
                default: state_next = ARB;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ARB;
            owner_reg      <= 2'd0;
            last_grant_reg <= 2'd3;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_grant_reg <= last_grant_next;
        end
    end

    // Accept and forward share the same cycle, so back-to-back beats leave no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 2'd0;
            out_last  <= 1'b0;
        end else if (load_en) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= chan_data[grant_idx];
                out_sel  <= grant_idx;
                out_last <= in_last[grant_idx];
            end
        end
    end

endmodule
